// File: rtl/cp0_exc_sequencer_pkg.sv
// Shared CP0 definitions: register indices, cause codes, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp0_pkg;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_IRQ     = 5'b00000;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h00400004;

    typedef enum logic [2:0] {
        IDLE, W_STATUS, W_CAUSE, W_EPC, X_REDIR, E_STATUS, E_REDIR, W_MTC0
    } state_t;

    typedef enum logic [1:0] {
        CLS_EXC, CLS_ERET, CLS_MTC0
    } req_class_t;

    // CAUSE register image: exception code sits in bits [6:2].
    function automatic logic [31:0] cause_word(input logic [4:0] code);
        return {24'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// Request/CP0-write bundle between decode/control, the sequencer and CP0.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until ack.
interface cp0_exc_sequencer_if;
    logic        syscall_req;
    logic        break_req;
    logic        teq_req;
    logic        irq;
    logic        eret_req;
    logic        mtc0_req;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] req_pc;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        pc_redir;
    logic [31:0] redir_pc;
    logic        ack;
    logic        busy;

    // Requester / CP0 side.
    modport master (
        output syscall_req, break_req, teq_req, irq, eret_req, mtc0_req,
               mtc0_addr, mtc0_data, req_pc, status_in, epc_in,
        input  cp0_we, cp0_waddr, cp0_wdata, pc_redir, redir_pc, ack, busy
    );

    // Sequencer side.
    modport slave (
        input  syscall_req, break_req, teq_req, irq, eret_req, mtc0_req,
               mtc0_addr, mtc0_data, req_pc, status_in, epc_in,
        output cp0_we, cp0_waddr, cp0_wdata, pc_redir, redir_pc, ack, busy
    );
endinterface

// File: rtl/cp0_exc_sequencer_prio.sv
// Fixed-priority selection among exception, ERET and MTC0 requests.
// Latency: combinational.
// Backpressure: none; losers simply remain asserted by their requesters.
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic       teq_req,
    input  logic       break_req,
    input  logic       syscall_req,
    input  logic       irq,
    input  logic       irq_en,
    input  logic       eret_req,
    input  logic       mtc0_req,
    output logic       vld,
    output logic [4:0] cause,
    output req_class_t cls
);

    // Highest-priority pending request wins; irq only counts when enabled.
    always_comb begin
        vld   = 1'b1;
        cause = CAUSE_IRQ;
        cls   = CLS_EXC;
        if (teq_req) begin
            cause = CAUSE_TEQ;
        end else if (break_req) begin
            cause = CAUSE_BREAK;
        end else if (syscall_req) begin
            cause = CAUSE_SYSCALL;
        end else if (irq && irq_en) begin
            cause = CAUSE_IRQ;
        end else if (eret_req) begin
            cls = CLS_ERET;
        end else if (mtc0_req) begin
            cls = CLS_MTC0;
        end else begin
            vld = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_sequencer.sv
// Turns one accepted exception/ERET/MTC0 request into a fixed series of CP0 writes, redirect and ack.
// Latency: exception 4 cycles to ack, ERET 2, MTC0 1; all outputs registered.
// Backpressure: requests sampled only in IDLE; requesters hold until ack and drop in the ack cycle.
module cp0_exc_sequencer
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned STATUS_SHIFT = 5
) (
    input  logic cp0_clk,
    input  logic cp0_rst,
    cp0_exc_sequencer_if.slave bus
);

    state_t      state_q, state_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;

    logic        p_vld;
    logic [4:0]  p_cause;
    req_class_t  p_cls;

    cp0_exc_prio u_prio (
        .teq_req     (bus.teq_req),
        .break_req   (bus.break_req),
        .syscall_req (bus.syscall_req),
        .irq         (bus.irq),
        .irq_en      (bus.status_in[0]),
        .eret_req    (bus.eret_req),
        .mtc0_req    (bus.mtc0_req),
        .vld         (p_vld),
        .cause       (p_cause),
        .cls         (p_cls)
    );

    // Next state plus the output values the next cycle will present.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        we_d       = 1'b0;
        waddr_d    = 5'd0;
        wdata_d    = 32'd0;
        redir_d    = 1'b0;
        redir_pc_d = 32'd0;
        ack_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p_vld) begin
                    unique case (p_cls)
                        CLS_EXC: begin
                            state_d = W_STATUS;
                            cause_d = p_cause;
                            // Interrupts resume at the interrupted PC, traps after it.
                            epc_d   = (p_cause == CAUSE_IRQ) ? bus.req_pc
                                                             : bus.req_pc + 32'd4;
                            we_d    = 1'b1;
                            waddr_d = REG_STATUS;
                            wdata_d = bus.status_in << STATUS_SHIFT;
                        end
                        CLS_ERET: begin
                            state_d = E_STATUS;
                            we_d    = 1'b1;
                            waddr_d = REG_STATUS;
                            wdata_d = bus.status_in >> STATUS_SHIFT;
                        end
                        CLS_MTC0: begin
                            state_d = W_MTC0;
                            we_d    = 1'b1;
                            waddr_d = bus.mtc0_addr;
                            wdata_d = bus.mtc0_data;
                            ack_d   = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            W_STATUS: begin
                state_d = W_CAUSE;
                we_d    = 1'b1;
                waddr_d = REG_CAUSE;
                wdata_d = cause_word(cause_q);
            end
            W_CAUSE: begin
                state_d = W_EPC;
                we_d    = 1'b1;
                waddr_d = REG_EPC;
                wdata_d = epc_q;
            end
            W_EPC: begin
                state_d    = X_REDIR;
                redir_d    = 1'b1;
                redir_pc_d = EXC_VECTOR;
                ack_d      = 1'b1;
            end
            E_STATUS: begin
                state_d    = E_REDIR;
                redir_d    = 1'b1;
                redir_pc_d = bus.epc_in;
                ack_d      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, latched request data and registered outputs; reset abandons any sequence.
    always_ff @(posedge cp0_clk or posedge cp0_rst) begin
        if (cp0_rst) begin
            state_q    <= IDLE;
            cause_q    <= 5'd0;
            epc_q      <= 32'd0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            redir_q    <= 1'b0;
            redir_pc_q <= 32'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cp0_we    = we_q;
    assign bus.cp0_waddr = waddr_q;
    assign bus.cp0_wdata = wdata_q;
    assign bus.pc_redir  = redir_q;
    assign bus.redir_pc  = redir_pc_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Scoreboard bench: a request-level model predicts every CP0 write/redirect/ack event.
// Latency: checks inter-event spacing inside and between back-to-back sequences.
// Backpressure: requests held until ack, dropped in the ack cycle.
module tb_cp0_exc_sequencer;

    localparam logic [31:0] VEC = 32'h00400004;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp0_exc_sequencer_if bus ();

    cp0_exc_sequencer #(.EXC_VECTOR(VEC), .STATUS_SHIFT(5)) dut (
        .cp0_clk (clk),
        .cp0_rst (rst),
        .bus     (bus)
    );

    typedef struct {
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        bit          redir;
        logic [31:0] rpc;
        bit          ack;
        int          gap;   // cycles since previous event, -1 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  last_ev_cyc = 0;

    // Monitor: every cycle with any CP0 activity must match the next predicted event.
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        cyc = cyc + 1;
        if (!rst && (bus.cp0_we || bus.pc_redir || bus.ack)) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event cyc=%0d got we=%0b addr=%0d data=%h redir=%0b rpc=%h ack=%0b required none",
                         cyc, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.pc_redir, bus.redir_pc, bus.ack);
            end else begin
                e  = exp_q.pop_front();
                ok = (bus.cp0_we == e.we) && (bus.pc_redir == e.redir) &&
                     (bus.ack == e.ack) && (bus.busy == 1'b1);
                if (e.we && (bus.cp0_waddr != e.waddr || bus.cp0_wdata != e.wdata)) ok = 0;
                if (e.redir && bus.redir_pc != e.rpc) ok = 0;
                if (e.gap >= 0 && (cyc - last_ev_cyc) != e.gap) ok = 0;
                if (!ok) begin
                    errors = errors + 1;
                    $display("FAIL event cyc=%0d got we=%0b addr=%0d data=%h redir=%0b rpc=%h ack=%0b busy=%0b gap=%0d required we=%0b addr=%0d data=%h redir=%0b rpc=%h ack=%0b gap=%0d",
                             cyc, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.pc_redir, bus.redir_pc,
                             bus.ack, bus.busy, cyc - last_ev_cyc, e.we, e.waddr, e.wdata, e.redir,
                             e.rpc, e.ack, e.gap);
                end
            end
            last_ev_cyc = cyc;
        end
    end

    // Request vector order: [5]=teq [4]=break [3]=syscall [2]=irq [1]=eret [0]=mtc0.
    function automatic int pick(input logic [5:0] r, input logic irq_en);
        if (r[5]) return 5;
        if (r[4]) return 4;
        if (r[3]) return 3;
        if (r[2] && irq_en) return 2;
        if (r[1]) return 1;
        if (r[0]) return 0;
        return -1;
    endfunction

    task automatic drive(input logic [5:0] r);
        bus.teq_req     = r[5];
        bus.break_req   = r[4];
        bus.syscall_req = r[3];
        bus.irq         = r[2];
        bus.eret_req    = r[1];
        bus.mtc0_req    = r[0];
    endtask

    task automatic push(input bit we, input logic [4:0] a, input logic [31:0] d,
                        input bit rd, input logic [31:0] rpc, input bit ak, input int gap);
        ev_t e;
        e.we = we; e.waddr = a; e.wdata = d; e.redir = rd; e.rpc = rpc; e.ack = ak; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Reference model: the event list a request class produces with the present inputs.
    task automatic push_exp(input int w, input int first_gap);
        logic [31:0] st_mul, st_div, epc_v;
        int code;
        st_mul = bus.status_in * 32'd32;
        st_div = bus.status_in / 32'd32;
        case (w)
            5: code = 13;
            4: code = 9;
            3: code = 8;
            default: code = 0;
        endcase
        if (w >= 2) begin
            epc_v = (w == 2) ? bus.req_pc : bus.req_pc + 32'd4;
            push(1, 5'd12, st_mul, 0, 0, 0, first_gap);
            push(1, 5'd13, 32'(code * 4), 0, 0, 0, 1);
            push(1, 5'd14, epc_v, 0, 0, 0, 1);
            push(0, 0, 0, 1, VEC, 1, 1);
        end else if (w == 1) begin
            push(1, 5'd12, st_div, 0, 0, 0, first_gap);
            push(0, 0, 0, 1, bus.epc_in, 1, 1);
        end else begin
            push(1, bus.mtc0_addr, bus.mtc0_data, 0, 0, 1, first_gap);
        end
    endtask

    task automatic rand_data();
        bus.status_in = $urandom;
        bus.req_pc    = $urandom & 32'hFFFF_FFFC;
        bus.epc_in    = $urandom;
        bus.mtc0_addr = 5'($urandom_range(0, 31));
        bus.mtc0_data = $urandom;
    endtask

    // Hold a set of requests, serve them in priority order, then confirm the block goes quiet.
    task automatic run_batch(input logic [5:0] r_in, input logic [31:0] st, input logic [31:0] pc,
                             input logic [31:0] epc, input logic [4:0] ma, input logic [31:0] md,
                             input bit rnd);
        logic [5:0] r;
        int  w;
        int  g;
        bit  got;
        bit  saw_busy;
        r = r_in;
        g = -1;
        @(negedge clk);
        bus.status_in = st; bus.req_pc = pc; bus.epc_in = epc;
        bus.mtc0_addr = ma; bus.mtc0_data = md;
        drive(r);
        forever begin
            w = pick(r, bus.status_in[0]);
            if (w < 0) break;
            push_exp(w, g);
            got = 0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                if (bus.ack) got = 1;
            end
            checks = checks + 1;
            if (!got) begin
                errors = errors + 1;
                $display("FAIL ack_timeout req=%0d got no ack required ack within 30 cycles", w);
                r = '0;
                drive(r);
                break;
            end
            r[w] = 1'b0;
            drive(r);
            if (rnd) rand_data();
            g = 2;
        end
        saw_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy) saw_busy = 1;
        end
        checks = checks + 1;
        if (saw_busy) begin
            errors = errors + 1;
            $display("FAIL idle_after_batch got busy=1 required busy=0 (pending=%b)", r);
        end
        r = '0;
        drive(r);
    endtask

    task automatic check_outputs_zero(input string name);
        checks = checks + 1;
        if (bus.cp0_we || bus.cp0_waddr != 0 || bus.cp0_wdata != 0 || bus.pc_redir ||
            bus.redir_pc != 0 || bus.ack || bus.busy) begin
            errors = errors + 1;
            $display("FAIL %s got we=%0b addr=%0d data=%h redir=%0b rpc=%h ack=%0b busy=%0b required all zero",
                     name, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.pc_redir, bus.redir_pc,
                     bus.ack, bus.busy);
        end
    endtask

    // Break sequence cut by reset in W_CAUSE, then restarted from the still-held request.
    task automatic reset_mid_sequence();
        bit got;
        @(negedge clk);
        bus.status_in = 32'h0000_0001;
        bus.req_pc    = 32'hFFFF_FFFC;
        drive(6'b010000);
        push(1, 5'd12, 32'h0000_0020, 0, 0, 0, -1);   // only the STATUS write escapes
        @(posedge clk);                               // acceptance
        @(posedge clk);                               // now in W_CAUSE
        #1 rst = 1'b1;
        #1 check_outputs_zero("reset_mid_seq");
        @(negedge clk);
        check_outputs_zero("reset_hold");
        rst = 1'b0;
        push_exp(4, -1);                              // EPC wraps to 0
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.ack) got = 1;
        end
        checks = checks + 1;
        if (!got) begin
            errors = errors + 1;
            $display("FAIL restart_after_reset got no ack required ack");
        end
        drive(6'b000000);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [5:0] rv;
        drive(6'b000000);
        bus.status_in = 0; bus.req_pc = 0; bus.epc_in = 0;
        bus.mtc0_addr = 0; bus.mtc0_data = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("idle_after_reset");

        run_batch(6'b001000, 32'h0000_001F, 32'h0040_0100, 0, 0, 0, 0);          // syscall
        run_batch(6'b101000, 32'h0000_001F, 32'h0040_0100, 0, 0, 0, 0);          // teq over syscall
        run_batch(6'b000100, 32'h0000_0000, 32'h0040_0200, 0, 0, 0, 0);          // irq masked
        run_batch(6'b000100, 32'h0000_0001, 32'h0040_0200, 0, 0, 0, 0);          // irq enabled
        run_batch(6'b000010, 32'h0000_03E0, 0, 32'h0040_0104, 0, 0, 0);          // eret
        run_batch(6'b010001, 32'h0000_0001, 32'h0040_0300, 0, 5'd9, 32'hDEAD_BEEF, 0); // mtc0 waits
        run_batch(6'b000101, 32'h0000_0000, 32'h0040_0400, 0, 5'd3, 32'h1234_5678, 0); // masked irq, mtc0 served
        reset_mid_sequence();

        for (int n = 0; n < 40; n++) begin
            rv = 6'($urandom_range(1, 63));
            run_batch(rv, $urandom, $urandom & 32'hFFFF_FFFC, $urandom,
                      5'($urandom_range(0, 31)), $urandom, 1);
        end

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_expected got %0d unconsumed events required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout got still running required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
